// File: rtl/controller_pkg.sv
// controller_pkg: state encoding, opcode constants, control code constants and the per-state output decode.
package controller_pkg;
  typedef enum logic [4:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPE_EX, RTYPE_WB,
    BEQ, BNE, ADDI_EX, ADDI_WB, JUMP, JAL, JR, INT_ACK, NMI_ACK
  } state_t;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [2:0] PC_ALU    = 3'b000;
  localparam logic [2:0] PC_ALUOUT = 3'b001;
  localparam logic [2:0] PC_JUMP   = 3'b010;
  localparam logic [2:0] PC_REGA   = 3'b011;
  localparam logic [2:0] PC_INTV   = 3'b100;
  localparam logic [2:0] PC_NMIV   = 3'b101;
  localparam logic [1:0] RD_RT = 2'b00;
  localparam logic [1:0] RD_RD = 2'b01;
  localparam logic [1:0] RD_RA = 2'b10;
  localparam logic [1:0] RD_K0 = 2'b11;
  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MEM    = 2'b01;
  localparam logic [1:0] M2R_PC     = 2'b10;
  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;
  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_FUNC = 2'b10;
  localparam logic [1:0] BR_NONE = 2'b00;
  localparam logic [1:0] BR_EQ   = 2'b01;
  localparam logic [1:0] BR_NE   = 2'b10;
  typedef struct packed {
    logic       pc_write;
    logic       lor_d;
    logic       mem_write;
    logic [1:0] mem_to_reg;
    logic       ir_write;
    logic [2:0] pc_src;
    logic [1:0] alu_op;
    logic [1:0] alu_src_b;
    logic       alu_src_a;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic       branch;
    logic [1:0] branch_eq_nq;
    logic       intrupt;
    logic       nmi_intrupt;
  } ctrl_t;
  function automatic ctrl_t outputs_of(state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.ir_write = 1'b1; c.alu_src_b = SRCB_FOUR; c.alu_op = ALU_ADD;
        c.pc_src = PC_ALU; c.pc_write = 1'b1;
      end
      DECODE: begin c.alu_src_b = SRCB_IMMSH; c.alu_op = ALU_ADD; end
      MEMADR: begin c.alu_src_a = 1'b1; c.alu_src_b = SRCB_IMM; c.alu_op = ALU_ADD; end
      MEMRD: c.lor_d = 1'b1;
      MEMWB: begin c.reg_dst = RD_RT; c.mem_to_reg = M2R_MEM; c.reg_write = 1'b1; end
      MEMWR: begin c.lor_d = 1'b1; c.mem_write = 1'b1; end
      RTYPE_EX: begin c.alu_src_a = 1'b1; c.alu_src_b = SRCB_B; c.alu_op = ALU_FUNC; end
      RTYPE_WB: begin c.reg_dst = RD_RD; c.mem_to_reg = M2R_ALUOUT; c.reg_write = 1'b1; end
      BEQ, BNE: begin
        c.alu_src_a = 1'b1; c.alu_src_b = SRCB_B; c.alu_op = ALU_SUB;
        c.pc_src = PC_ALUOUT; c.branch = 1'b1;
        c.branch_eq_nq = (s == BEQ) ? BR_EQ : BR_NE;
      end
      ADDI_EX: begin c.alu_src_a = 1'b1; c.alu_src_b = SRCB_IMM; c.alu_op = ALU_ADD; end
      ADDI_WB: begin c.reg_dst = RD_RT; c.mem_to_reg = M2R_ALUOUT; c.reg_write = 1'b1; end
      JUMP: begin c.pc_src = PC_JUMP; c.pc_write = 1'b1; end
      JAL: begin
        c.pc_src = PC_JUMP; c.pc_write = 1'b1;
        c.reg_dst = RD_RA; c.mem_to_reg = M2R_PC; c.reg_write = 1'b1;
      end
      JR: begin c.pc_src = PC_REGA; c.pc_write = 1'b1; end
      INT_ACK, NMI_ACK: begin
        c.reg_dst = RD_K0; c.mem_to_reg = M2R_PC; c.reg_write = 1'b1; c.pc_write = 1'b1;
        c.pc_src = (s == NMI_ACK) ? PC_NMIV : PC_INTV;
        c.intrupt = (s == INT_ACK);
        c.nmi_intrupt = (s == NMI_ACK);
      end
      default: c = '0;
    endcase
    return c;
  endfunction
endpackage

// File: rtl/controller_if.sv
// controller_if: instruction fields, interrupt requests and control outputs of the multicycle controller.
interface controller_if;
  logic [5:0] Op, Func;
  logic       INT, NMI, INT_FLAG;
  logic       PCWrite, lorD, MemWrite, IRWrite, ALUSrcA, RegWrite, Branch, intrupt, nmi_intrupt;
  logic [1:0] MemtoReg, ALUOp, ALUSrcB, RegDst, BRANCH_EQ_NQ;
  logic [2:0] PCSrc;
  modport master (
    output Op, Func, INT, NMI, INT_FLAG,
    input  PCWrite, lorD, MemWrite, MemtoReg, IRWrite, PCSrc, ALUOp, ALUSrcB, ALUSrcA,
           RegWrite, RegDst, Branch, BRANCH_EQ_NQ, intrupt, nmi_intrupt
  );
  modport slave (
    input  Op, Func, INT, NMI, INT_FLAG,
    output PCWrite, lorD, MemWrite, MemtoReg, IRWrite, PCSrc, ALUOp, ALUSrcB, ALUSrcA,
           RegWrite, RegDst, Branch, BRANCH_EQ_NQ, intrupt, nmi_intrupt
  );
endinterface

// File: rtl/nmi_edge_detect.sv
// nmi_edge_detect: latches a rising NMI edge as pending until the acknowledge is entered.
module nmi_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic nmi,
  input  logic clear,
  output logic pending
);
  logic prev;
  always_ff @(posedge clk) begin
    if (rst) begin
      prev <= 1'b0;
      pending <= 1'b0;
    end else begin
      prev <= nmi;
      pending <= (pending & ~clear) | (nmi & ~prev);
    end
  end
endmodule

// File: rtl/controller.sv
// controller: Moore multicycle control FSM with maskable and non-maskable interrupt acknowledge.
module controller
  import controller_pkg::*;
(
  input  logic       Clk,
  input  logic       Reset,
  input  logic [5:0] Op,
  input  logic [5:0] Func,
  input  logic       INT,
  input  logic       NMI,
  input  logic       INT_FLAG,
  output logic       PCWrite,
  output logic       lorD,
  output logic       MemWrite,
  output logic [1:0] MemtoReg,
  output logic       IRWrite,
  output logic [2:0] PCSrc,
  output logic [1:0] ALUOp,
  output logic [1:0] ALUSrcB,
  output logic       ALUSrcA,
  output logic       RegWrite,
  output logic [1:0] RegDst,
  output logic       Branch,
  output logic [1:0] BRANCH_EQ_NQ,
  output logic       intrupt,
  output logic       nmi_intrupt
);
  state_t state, next, after_done;
  logic   nmi_pending;
  ctrl_t  c;
  // every instruction-ending state shares this interrupt choice
  assign after_done = nmi_pending ? NMI_ACK : (INT && INT_FLAG) ? INT_ACK : FETCH;
  always_comb begin
    next = after_done;
    case (state)
      FETCH:    next = DECODE;
      DECODE:   next = (Op == OP_LW || Op == OP_SW) ? MEMADR :
                       (Op == OP_RTYPE) ? ((Func == FN_JR) ? JR : RTYPE_EX) :
                       (Op == OP_BEQ)   ? BEQ :
                       (Op == OP_BNE)   ? BNE :
                       (Op == OP_ADDI)  ? ADDI_EX :
                       (Op == OP_J)     ? JUMP :
                       (Op == OP_JAL)   ? JAL : after_done;
      MEMADR:   next = (Op == OP_SW) ? MEMWR : MEMRD;
      MEMRD:    next = MEMWB;
      RTYPE_EX: next = RTYPE_WB;
      ADDI_EX:  next = ADDI_WB;
      default:  next = after_done;
    endcase
  end
  nmi_edge_detect u_nmi (
    .clk(Clk),
    .rst(Reset),
    .nmi(NMI),
    .clear(next == NMI_ACK),
    .pending(nmi_pending)
  );
  always_ff @(posedge Clk) state <= Reset ? FETCH : next;
  assign c = Reset ? '0 : outputs_of(state);
  assign {PCWrite, lorD, MemWrite, MemtoReg, IRWrite, PCSrc, ALUOp, ALUSrcB, ALUSrcA,
          RegWrite, RegDst, Branch, BRANCH_EQ_NQ, intrupt, nmi_intrupt} = c;
endmodule

// File: tb/tb_controller.sv
// tb_controller: directed and random checks of the controller against an instruction-level model.
module tb_controller;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  controller_if bus ();
  controller dut (
    .Clk(clk), .Reset(rst), .Op(bus.Op), .Func(bus.Func), .INT(bus.INT), .NMI(bus.NMI),
    .INT_FLAG(bus.INT_FLAG), .PCWrite(bus.PCWrite), .lorD(bus.lorD), .MemWrite(bus.MemWrite),
    .MemtoReg(bus.MemtoReg), .IRWrite(bus.IRWrite), .PCSrc(bus.PCSrc), .ALUOp(bus.ALUOp),
    .ALUSrcB(bus.ALUSrcB), .ALUSrcA(bus.ALUSrcA), .RegWrite(bus.RegWrite), .RegDst(bus.RegDst),
    .Branch(bus.Branch), .BRANCH_EQ_NQ(bus.BRANCH_EQ_NQ), .intrupt(bus.intrupt),
    .nmi_intrupt(bus.nmi_intrupt)
  );
  int total = 0;
  int passed = 0;
  string cur;
  string path[$];
  logic [11:0] iq[$];
  logic pend, prev_n;
  function automatic logic [21:0] obs();
    return {bus.PCWrite, bus.lorD, bus.MemWrite, bus.MemtoReg, bus.IRWrite, bus.PCSrc,
            bus.ALUOp, bus.ALUSrcB, bus.ALUSrcA, bus.RegWrite, bus.RegDst, bus.Branch,
            bus.BRANCH_EQ_NQ, bus.intrupt, bus.nmi_intrupt};
  endfunction
  function automatic logic [21:0] expv(string s);
    logic pcw, lord, mw, irw, asa, rw, br, it, nt;
    logic [1:0] m2r, aop, asb, rd, beq;
    logic [2:0] pcs;
    {pcw, lord, mw, irw, asa, rw, br, it, nt} = '0;
    {m2r, aop, asb, rd, beq, pcs} = '0;
    case (s)
      "FETCH":    begin irw = 1; asb = 2'b01; pcw = 1; end
      "DECODE":   asb = 2'b11;
      "MEMADR":   begin asa = 1; asb = 2'b10; end
      "MEMRD":    lord = 1;
      "MEMWB":    begin m2r = 2'b01; rw = 1; end
      "MEMWR":    begin lord = 1; mw = 1; end
      "RTYPE_EX": begin asa = 1; aop = 2'b10; end
      "RTYPE_WB": begin rd = 2'b01; rw = 1; end
      "BEQ":      begin asa = 1; aop = 2'b01; pcs = 3'b001; br = 1; beq = 2'b01; end
      "BNE":      begin asa = 1; aop = 2'b01; pcs = 3'b001; br = 1; beq = 2'b10; end
      "ADDI_EX":  begin asa = 1; asb = 2'b10; end
      "ADDI_WB":  rw = 1;
      "JUMP":     begin pcs = 3'b010; pcw = 1; end
      "JAL":      begin pcs = 3'b010; pcw = 1; rd = 2'b10; m2r = 2'b10; rw = 1; end
      "JR":       begin pcs = 3'b011; pcw = 1; end
      "INT_ACK":  begin rd = 2'b11; m2r = 2'b10; rw = 1; pcs = 3'b100; pcw = 1; it = 1; end
      "NMI_ACK":  begin rd = 2'b11; m2r = 2'b10; rw = 1; pcs = 3'b101; pcw = 1; nt = 1; end
      default:    return '1;
    endcase
    return {pcw, lord, mw, m2r, irw, pcs, aop, asb, asa, rw, rd, br, beq, it, nt};
  endfunction
  function automatic logic [11:0] rand_instr();
    int k;
    logic [5:0] fn;
    k = $urandom_range(0, 9);
    fn = 6'($urandom);
    case (k)
      0: return {6'b100011, fn};
      1: return {6'b101011, fn};
      2: return {6'b000000, fn};
      3: return {6'b000000, 6'b001000};
      4: return {6'b000100, fn};
      5: return {6'b000101, fn};
      6: return {6'b001000, fn};
      7: return {6'b000010, fn};
      8: return {6'b000011, fn};
      default: return {2'b11, 4'($urandom), fn};
    endcase
  endfunction
  // drive this cycle's inputs and advance the model to the state seen after the next edge
  task automatic step(input logic i, input logic f, input logic n);
    logic [11:0] ins;
    string nxt;
    bus.INT = i;
    bus.INT_FLAG = f;
    bus.NMI = n;
    if (cur == "FETCH") begin
      ins = (iq.size() != 0) ? iq.pop_front() : rand_instr();
      bus.Op = ins[11:6];
      bus.Func = ins[5:0];
      path.delete();
      case (ins[11:6])
        6'b100011: begin path.push_back("MEMADR"); path.push_back("MEMRD"); path.push_back("MEMWB"); end
        6'b101011: begin path.push_back("MEMADR"); path.push_back("MEMWR"); end
        6'b000000: if (ins[5:0] == 6'b001000) path.push_back("JR");
                   else begin path.push_back("RTYPE_EX"); path.push_back("RTYPE_WB"); end
        6'b000100: path.push_back("BEQ");
        6'b000101: path.push_back("BNE");
        6'b001000: begin path.push_back("ADDI_EX"); path.push_back("ADDI_WB"); end
        6'b000010: path.push_back("JUMP");
        6'b000011: path.push_back("JAL");
        default: ;
      endcase
      nxt = "DECODE";
    end else if (path.size() != 0) nxt = path.pop_front();
    else nxt = pend ? "NMI_ACK" : (i && f) ? "INT_ACK" : "FETCH";
    if (nxt == "NMI_ACK") pend = 1'b0;
    if (n && !prev_n) pend = 1'b1;
    prev_n = n;
    cur = nxt;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    bus.Op = 6'b100011; bus.Func = '0; bus.INT = 0; bus.INT_FLAG = 0; bus.NMI = 0;
    repeat (2) begin
      @(negedge clk);
      total++;
      if (obs() !== '0) $display("FAIL reset_outputs got %h want 0", obs());
      else passed++;
    end
    rst = 1'b0;
    cur = "FETCH"; pend = 0; prev_n = 0; path.delete();
    iq.push_back({6'b100011, 6'b000000});
    #1;
    total++;
    if (obs() !== expv(cur)) $display("FAIL lw_%s got %h want %h", cur, obs(), expv(cur));
    else passed++;
    for (int k = 1; k <= 5; k++) begin
      step(0, 0, 0);
      @(negedge clk);
      total++;
      if (obs() !== expv(cur)) $display("FAIL lw_%s got %h want %h", cur, obs(), expv(cur));
      else passed++;
      if (k == 4) begin
        total++;
        if ({bus.RegWrite, bus.MemtoReg} !== 3'b101)
          $display("FAIL memwb_fields got %b want 101", {bus.RegWrite, bus.MemtoReg});
        else passed++;
      end
    end
  endtask
  task automatic test_jr();
    iq.push_back({6'b000000, 6'b001000});
    for (int k = 1; k <= 3; k++) begin
      step(0, 0, 0);
      @(negedge clk);
      total++;
      if (obs() !== expv(cur)) $display("FAIL jr_%s got %h want %h", cur, obs(), expv(cur));
      else passed++;
      if (k == 2) begin
        total++;
        if ({bus.PCSrc, bus.PCWrite} !== 4'b0111)
          $display("FAIL jr_fields got %b want 0111", {bus.PCSrc, bus.PCWrite});
        else passed++;
      end
    end
  endtask
  task automatic test_bne();
    iq.push_back({6'b000101, 6'b010101});
    for (int k = 1; k <= 3; k++) begin
      step(0, 0, 0);
      @(negedge clk);
      total++;
      if (obs() !== expv(cur)) $display("FAIL bne_%s got %h want %h", cur, obs(), expv(cur));
      else passed++;
      if (k == 2) begin
        total++;
        if ({bus.Branch, bus.BRANCH_EQ_NQ, bus.ALUOp, bus.PCSrc} !== 8'b1_10_01_001)
          $display("FAIL bne_fields got %b want 11001001",
                   {bus.Branch, bus.BRANCH_EQ_NQ, bus.ALUOp, bus.PCSrc});
        else passed++;
      end
    end
  endtask
  task automatic test_jal();
    iq.push_back({6'b000011, 6'b000000});
    for (int k = 1; k <= 3; k++) begin
      step(0, 0, 0);
      @(negedge clk);
      total++;
      if (obs() !== expv(cur)) $display("FAIL jal_%s got %h want %h", cur, obs(), expv(cur));
      else passed++;
      if (k == 2) begin
        total++;
        if ({bus.RegDst, bus.MemtoReg, bus.RegWrite, bus.PCSrc} !== 8'b10_10_1_010)
          $display("FAIL jal_fields got %b want 10101010",
                   {bus.RegDst, bus.MemtoReg, bus.RegWrite, bus.PCSrc});
        else passed++;
      end
    end
  endtask
  task automatic test_int_mask();
    iq.push_back({6'b001000, 6'b000000});
    for (int k = 1; k <= 4; k++) begin
      step(1, 0, 0);
      @(negedge clk);
      total++;
      if (obs() !== expv(cur) || bus.intrupt !== 1'b0)
        $display("FAIL masked_%s got %h want %h", cur, obs(), expv(cur));
      else passed++;
    end
    iq.push_back({6'b001000, 6'b000000});
    for (int k = 1; k <= 5; k++) begin
      if (k < 5) step(1, 1, 0);
      else step(0, 1, 0);
      @(negedge clk);
      total++;
      if (obs() !== expv(cur)) $display("FAIL int_%s got %h want %h", cur, obs(), expv(cur));
      else passed++;
      if (k >= 4) begin
        total++;
        if ({bus.intrupt, bus.PCSrc, bus.RegDst} !== ((k == 4) ? 6'b1_100_11 : {1'b0, 3'b000, 2'b00}))
          $display("FAIL int_ack_fields_%0d got %b", k, {bus.intrupt, bus.PCSrc, bus.RegDst});
        else passed++;
      end
    end
  endtask
  task automatic test_nmi();
    iq.push_back({6'b001000, 6'b000000});
    for (int k = 1; k <= 6; k++) begin
      step(k < 6, 1, k >= 2);
      @(negedge clk);
      total++;
      if (obs() !== expv(cur)) $display("FAIL nmi_%s got %h want %h", cur, obs(), expv(cur));
      else passed++;
      if (k == 4) begin
        total++;
        if ({bus.nmi_intrupt, bus.intrupt, bus.PCSrc} !== 5'b1_0_101)
          $display("FAIL nmi_ack_fields got %b want 10101", {bus.nmi_intrupt, bus.intrupt, bus.PCSrc});
        else passed++;
      end
      if (k == 5) begin
        total++;
        if ({bus.nmi_intrupt, bus.intrupt} !== 2'b01)
          $display("FAIL nmi_then_int got %b want 01", {bus.nmi_intrupt, bus.intrupt});
        else passed++;
      end
    end
  endtask
  task automatic test_nop_int();
    iq.push_back({6'b111111, 6'b000000});
    for (int k = 1; k <= 3; k++) begin
      step(k < 3, 1, 0);
      @(negedge clk);
      total++;
      if (obs() !== expv(cur)) $display("FAIL nop_%s got %h want %h", cur, obs(), expv(cur));
      else passed++;
      if (k == 2) begin
        total++;
        if (bus.intrupt !== 1'b1) $display("FAIL nop_int_ack got %b want 1", bus.intrupt);
        else passed++;
      end
    end
  endtask
  task automatic test_random();
    logic nv;
    nv = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 5) == 0) nv = ~nv;
      step(1'($urandom), 1'($urandom), nv);
      @(negedge clk);
      total++;
      if (obs() !== expv(cur)) $display("FAIL rand_%0d_%s got %h want %h", k, cur, obs(), expv(cur));
      else passed++;
    end
  endtask
  initial begin
    test_reset();
    test_jr();
    test_bne();
    test_jal();
    test_int_mask();
    test_nmi();
    test_nop_int();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/controller.md
CONTROLLER -- requirements
Module: controller

Interface
REQ-001 SHALL have exactly one clock and one reset port.
REQ-002 SHALL provide the ports below; Clk and Reset are listed first, and no other ports are added.
- Clk in 1: rising-edge clock.
- Reset in 1: synchronous, active-high.
- Op in 6: opcode.
- Func in 6: R-type function field.
- INT in 1: maskable interrupt request, level-sensitive.
- NMI in 1: non-maskable interrupt request.
- INT_FLAG in 1: interrupt enable; 1 = INT allowed.
- PCWrite out 1: PC load.
- lorD out 1: memory address select; 0 = PC, 1 = ALUOut.
- MemWrite out 1: memory write.
- MemtoReg out 2: write-back data; 00 = ALUOut, 01 = MemData, 10 = PC.
- IRWrite out 1: instruction register load.
- PCSrc out 3: PC source; 000 = ALUResult, 001 = ALUOut, 010 = jump target, 011 = register A, 100 = INT vector, 101 = NMI vector.
- ALUOp out 2: 00 = add, 01 = sub, 10 = decode Func.
- ALUSrcB out 2: 00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate shifted left 2.
- ALUSrcA out 1: 0 = PC, 1 = A.
- RegWrite out 1: register file write.
- RegDst out 2: 00 = rt, 01 = rd, 10 = $31, 11 = $26.
- Branch out 1: conditional PC write enable.
- BRANCH_EQ_NQ out 2: 01 = BEQ, 10 = BNE, 00 = no branch.
- intrupt out 1: INT acknowledge pulse.
- nmi_intrupt out 1: NMI acknowledge pulse.

Function
REQ-003 SHALL be a Moore multicycle FSM; all outputs decode from the current state only; any output not listed for a state is 0.
REQ-004 SHALL assign these state outputs:
- FETCH: lorD=0, IRWrite=1, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=000, PCWrite=1.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00.
- MEMRD: lorD=1.
- MEMWB: RegDst=00, MemtoReg=01, RegWrite=1.
- MEMWR: lorD=1, MemWrite=1.
- RTYPE_EX: ALUSrcA=1, ALUSrcB=00, ALUOp=10.
- RTYPE_WB: RegDst=01, MemtoReg=00, RegWrite=1.
- BEQ / BNE: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=001, Branch=1, BRANCH_EQ_NQ=01 / 10 respectively.
- ADDI_EX: ALUSrcA=1, ALUSrcB=10, ALUOp=00.
- ADDI_WB: RegDst=00, MemtoReg=00, RegWrite=1.
- JUMP: PCSrc=010, PCWrite=1.
- JAL: PCSrc=010, PCWrite=1, RegDst=10, MemtoReg=10, RegWrite=1.
- JR: PCSrc=011, PCWrite=1.
- INT_ACK: RegDst=11, MemtoReg=10, RegWrite=1, PCSrc=100, PCWrite=1, intrupt=1.
- NMI_ACK: same as INT_ACK except PCSrc=101, nmi_intrupt=1, intrupt=0.
REQ-005 SHALL make FETCH go to DECODE unconditionally.
REQ-006 SHALL decode Op in DECODE to the next state:
- 100011 (LW) or 101011 (SW) -> MEMADR.
- 000000 -> JR when Func=001000, else RTYPE_EX.
- 000100 -> BEQ.
- 000101 -> BNE.
- 001000 -> ADDI_EX.
- 000010 -> JUMP.
- 000011 -> JAL.
- any other Op -> FETCH, treated as a NOP.
REQ-007 SHALL make MEMADR go to MEMRD for LW and MEMWR for SW; MEMRD -> MEMWB; RTYPE_EX -> RTYPE_WB; ADDI_EX -> ADDI_WB.
REQ-008 SHALL treat MEMWB, MEMWR, RTYPE_WB, ADDI_WB, BEQ, BNE, JUMP, JAL, JR, INT_ACK and NMI_ACK as terminal states, and make the same choice from every terminal state:
- NMI pending -> NMI_ACK;
- else INT=1 and INT_FLAG=1 -> INT_ACK;
- else FETCH.
REQ-009 SHALL also treat the undefined-opcode exit from DECODE as terminal, applying the choice in REQ-008.
REQ-010 SHALL detect NMI on its rising edge (0 -> 1 between consecutive clock samples) and set an internal nmi_pending flag; entering NMI_ACK clears it; a new edge in that same cycle re-sets it.
REQ-011 SHALL ignore INT entirely when INT_FLAG=0.
REQ-012 SHALL give NMI priority when NMI is pending and INT is requested simultaneously.
REQ-013 SHALL never interrupt an instruction mid-sequence; INT/NMI arriving in FETCH, DECODE or a middle state is held until the next terminal state.
REQ-014 SHALL assert intrupt and nmi_intrupt for exactly one cycle per acknowledge.

Reset
REQ-015 SHALL, on Clk rising edge with Reset=1, set state to FETCH, clear nmi_pending and clear the previous-NMI sample.
REQ-016 SHALL force every output to 0 combinationally while Reset=1; the first cycle after Reset falls is FETCH.

Structure
REQ-017 SHALL place the state encoding (5-bit enum), opcode/function constants, and the PCSrc/RegDst/MemtoReg/ALUSrcB/ALUOp/BRANCH_EQ_NQ code constants in a shared package controller_pkg.
REQ-018 SHALL optionally use one sub-module, nmi_edge_detect, holding the NMI sample register and the pending flag; the rest is one FSM.

Verification
REQ-019 Reset=1 two cycles, then release, Op=100011 -> all outputs 0 during reset; then FETCH, DECODE, MEMADR, MEMRD, MEMWB, FETCH (6 cycles); MemWB has RegWrite=1 and MemtoReg=01.
REQ-020 Op=000000, Func=001000 -> FETCH, DECODE, JR; JR has PCSrc=011 and PCWrite=1.
REQ-021 Op=000101 -> BNE state has Branch=1, BRANCH_EQ_NQ=10, ALUOp=01, PCSrc=001.
REQ-022 During an ADDI, INT=1 and INT_FLAG=0 -> no INT_ACK; repeat with INT_FLAG=1 -> INT_ACK follows ADDI_WB with intrupt=1 for one cycle, PCSrc=100, RegDst=11.
REQ-023 NMI rises 0->1 in DECODE while INT=1 and INT_FLAG=1 -> NMI_ACK after the terminal state with nmi_intrupt=1 and PCSrc=101; NMI held high -> no second NMI_ACK; INT_ACK follows next.
REQ-024 Op=000011 -> JAL state has RegDst=10, MemtoReg=10, RegWrite=1, PCSrc=010.
